// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters with one-cycle lookup,
// resolution-time update, mispredict/redirect pulse and a saturating mispredict counter.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fetch_valid,
  input  logic [DATA_WIDTH-1:0] i_fetch_pc,
  output logic                  o_pred_valid,
  output logic                  o_pred_taken,
  output logic [DATA_WIDTH-1:0] o_pred_pc,
  input  logic                  i_res_valid,
  input  logic [DATA_WIDTH-1:0] i_res_pc,
  input  logic                  i_res_take,
  input  logic                  i_res_pred,
  input  logic [DATA_WIDTH-1:0] i_res_target,
  output logic                  o_mispredict,
  output logic [DATA_WIDTH-1:0] o_redirect_pc,
  output logic [15:0]           o_mispredict_cnt
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [1:0]    pht [ENTRIES];
  logic [IW-1:0] fetch_idx;
  logic [IW-1:0] res_idx;
  logic          mispredict;
  logic [1:0]    res_ctr;
  logic [1:0]    res_ctr_next;

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign fetch_idx  = i_fetch_pc[IW+1:2];
  assign res_idx    = i_res_pc[IW+1:2];
  assign mispredict = i_res_valid && (i_res_take != i_res_pred);
  assign res_ctr    = pht[res_idx];

  always_comb begin
    res_ctr_next = res_ctr;
    if (i_res_take && (res_ctr != 2'b11))
      res_ctr_next = res_ctr + 2'd1;
    else if (!i_res_take && (res_ctr != 2'b00))
      res_ctr_next = res_ctr - 2'd1;
  end

  // Lookup reads the table before this edge's update lands (read-before-write).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b01;
    end else if (i_res_valid) begin
      pht[res_idx] <= res_ctr_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pred_valid <= 1'b0;
      o_pred_taken <= 1'b0;
      o_pred_pc    <= '0;
    end else begin
      o_pred_valid <= i_fetch_valid && !mispredict;
      if (i_fetch_valid) begin
        o_pred_taken <= pht[fetch_idx][1];
        o_pred_pc    <= i_fetch_pc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mispredict     <= 1'b0;
      o_redirect_pc    <= '0;
      o_mispredict_cnt <= '0;
    end else begin
      o_mispredict <= mispredict;
      if (mispredict) begin
        o_redirect_pc <= i_res_take ? i_res_target : i_res_pc + DATA_WIDTH'(4);
        if (o_mispredict_cnt != 16'hFFFF)
          o_mispredict_cnt <= o_mispredict_cnt + 16'd1;
      end
    end
  end

endmodule
